sim_step_ctrl: RTL and testbench

SIM_STEP_CTRL -- requirements
Module: sim_step_ctrl

---
 rtl/sim_step_ctrl.sv | 140 ++++++++++++++
 tb/tb_sim_step_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_step_ctrl.sv
// Host register file plus step-request/acknowledge sequencer for a physics engine.
// Reads return one cycle after the strobe; host body writes are locked out while a run is active.
module sim_step_ctrl #(
    parameter int NUM_WORDS = 93,
    parameter int STEP_W    = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       AVL_CS,
    input  logic                       AVL_READ,
    input  logic                       AVL_WRITE,
    input  logic [6:0]                 AVL_ADDR,
    input  logic [3:0]                 AVL_BYTE_EN,
    input  logic [31:0]                AVL_WRITEDATA,
    output logic [31:0]                AVL_READDATA,
    input  logic                       ENG_WE,
    input  logic [6:0]                 ENG_ADDR,
    input  logic [31:0]                ENG_WDATA,
    output logic                       FSM_START,
    input  logic                       FSM_DONE,
    output logic [NUM_WORDS-1:0][31:0] datafile,
    output logic                       BUSY
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_CMPL} state_t;

    localparam logic [7:0] NW = 8'(NUM_WORDS);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              done_q;
    logic              abort_q, abort_d;
    logic              start_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_q [NUM_WORDS];

    logic              host_wr, host_rd, addr_ok, body_wr, word1_wr, start_wr, eng_ok;
    logic [STEP_W-1:0] n_wr, n_cur;
    logic [15:0]       cnt_rd;
    logic [31:0]       status;

    assign host_wr  = AVL_CS & AVL_WRITE;
    assign host_rd  = AVL_CS & AVL_READ;
    assign addr_ok  = {1'b0, AVL_ADDR} < NW;
    assign body_wr  = host_wr && addr_ok && (state_q == S_IDLE)
                      && (AVL_ADDR == 7'd0 || AVL_ADDR >= 7'd3);
    assign word1_wr = host_wr && (AVL_ADDR == 7'd1);
    assign n_wr     = AVL_WRITEDATA[STEP_W-1:0];
    assign n_cur    = mem_q[1][STEP_W-1:0];
    assign start_wr = word1_wr && (state_q == S_IDLE) && (n_wr != '0);
    assign eng_ok   = ENG_WE && (state_q == S_REQ || state_q == S_REL)
                      && (ENG_ADDR >= 7'd3) && ({1'b0, ENG_ADDR} < NW);

    assign BUSY         = (state_q != S_IDLE);
    assign FSM_START    = start_q;
    assign AVL_READDATA = rdata_q;
    assign cnt_rd       = 16'(cnt_q);
    assign status       = {cnt_rd, 14'd0, BUSY, done_q};

    // Word 2 is not stored; the engine sees the same status the host reads.
    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            datafile[i] = mem_q[i];
        end
        datafile[2] = status;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        if (word1_wr && (state_q != S_IDLE) && (AVL_WRITEDATA == '0)) begin
            abort_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start_wr) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (FSM_DONE) begin
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!FSM_DONE) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ((cnt_d == n_cur) || abort_q) ? S_CMPL : S_REQ;
                end
            end
            S_CMPL: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            start_q <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            start_q <= (state_d == S_REQ);
            if (start_wr) begin
                done_q <= 1'b0;
            end else if (state_q == S_CMPL) begin
                done_q <= 1'b1;
            end
            // Sampled before this edge's writes land, so a colliding engine write is not seen.
            if (host_rd) begin
                rdata_q <= !addr_ok ? '0 : (AVL_ADDR == 7'd2) ? status : mem_q[AVL_ADDR];
            end
            if (body_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (AVL_BYTE_EN[b]) begin
                        mem_q[AVL_ADDR][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
                    end
                end
            end
            if (word1_wr && (state_q == S_IDLE)) begin
                mem_q[1] <= 32'(n_wr);
            end
            if (eng_ok) begin
                mem_q[ENG_ADDR] <= ENG_WDATA;
            end
        end
    end
endmodule

// File: tb/tb_sim_step_ctrl.sv
// Randomized bench for sim_step_ctrl against a behavioural model of the register map and run sequencing.
module tb_sim_step_ctrl;
    localparam int NW = 93;
    localparam int SW = 16;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic                AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
    logic [6:0]          AVL_ADDR = '0;
    logic [3:0]          AVL_BYTE_EN = '0;
    logic [31:0]         AVL_WRITEDATA = '0;
    logic [31:0]         AVL_READDATA;
    logic                ENG_WE = 1'b0;
    logic [6:0]          ENG_ADDR = '0;
    logic [31:0]         ENG_WDATA = '0;
    logic                FSM_START;
    logic                FSM_DONE = 1'b0;
    logic [NW-1:0][31:0] datafile;
    logic                BUSY;

    sim_step_ctrl #(.NUM_WORDS(NW), .STEP_W(SW)) dut (
        .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .ENG_WE(ENG_WE), .ENG_ADDR(ENG_ADDR), .ENG_WDATA(ENG_WDATA),
        .FSM_START(FSM_START), .FSM_DONE(FSM_DONE), .datafile(datafile), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int   vectors = 0, miscompares = 0;
    int   hi_dly = 2, lo_dly = 0, eng_age = 0, eng_low = 0;
    logic eng_auto = 1'b1;
    int   pulses = 0;
    logic prev_start = 1'b0;
    logic chk_on = 1'b0;

    // Model: run phase 0 idle, 1 requesting, 2 releasing, 3 completing.
    logic [31:0] m_mem [NW];
    int          m_phase;
    logic [15:0] m_cnt;
    logic        m_done, m_abort;
    logic [31:0] m_rd;

    function automatic logic [31:0] m_word(input int a);
        if (a == 2) return {m_cnt, 14'd0, (m_phase != 0), m_done};
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) m_mem[i] = '0;
        m_phase = 0; m_cnt = '0; m_done = 1'b0; m_abort = 1'b0; m_rd = '0;
    endtask

    task automatic model_step();
        int a, ea, nxt;
        logic ab;
        logic [15:0] n;
        a = int'(AVL_ADDR); ea = int'(ENG_ADDR); nxt = m_phase; ab = m_abort;
        if (AVL_CS && AVL_READ) m_rd = (a < NW) ? m_word(a) : 32'h0;
        if (AVL_CS && AVL_WRITE && a < NW) begin
            if (a == 1) begin
                if (m_phase == 0) begin
                    n = AVL_WRITEDATA[15:0];
                    m_mem[1] = {16'h0, n};
                    if (n != 0) begin m_cnt = '0; m_done = 1'b0; nxt = 1; end
                end else if (AVL_WRITEDATA == 32'h0) begin
                    ab = 1'b1;
                end
            end else if (a != 2 && m_phase == 0) begin
                for (int b = 0; b < 4; b++)
                    if (AVL_BYTE_EN[b]) m_mem[a][8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
            end
        end
        if (ENG_WE && (m_phase == 1 || m_phase == 2) && ea >= 3 && ea < NW) m_mem[ea] = ENG_WDATA;
        case (m_phase)
            1: if (FSM_DONE) nxt = 2;
            2: if (!FSM_DONE) begin
                   m_cnt = m_cnt + 16'd1;
                   nxt = (m_cnt == m_mem[1][15:0] || m_abort) ? 3 : 1;
               end
            3: begin m_done = 1'b1; ab = 1'b0; nxt = 0; end
            default: ;
        endcase
        m_abort = ab;
        m_phase = nxt;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic df_chk(input string nm, input logic zero);
        int bad;
        logic [31:0] e, eb;
        bad = -1; eb = '0;
        for (int i = 0; i < NW; i++) begin
            e = zero ? 32'h0 : m_word(i);
            if (datafile[i] !== e && bad < 0) begin bad = i; eb = e; end
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s datafile[%0d]: got 0x%08h, expected 0x%08h", nm, bad, datafile[bad], eb);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET && chk_on) begin
            chk("start", {31'd0, FSM_START}, {31'd0, (m_phase == 1)});
            chk("busy", {31'd0, BUSY}, {31'd0, (m_phase != 0)});
            chk("readdata", AVL_READDATA, m_rd);
            df_chk("model", 1'b0);
        end
    end

    task automatic engine();
        if (!eng_auto) return;
        if (FSM_START) begin
            eng_age++; eng_low = 0;
            if (eng_age >= hi_dly) FSM_DONE = 1'b1;
        end else begin
            eng_age = 0;
            if (FSM_DONE) begin
                if (eng_low >= lo_dly) begin FSM_DONE = 1'b0; eng_low = 0; end
                else eng_low++;
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        engine();
        if (FSM_START && !prev_start) pulses++;
        prev_start = FSM_START;
    endtask

    task automatic clear_inputs();
        AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; ENG_WE = 1'b0;
    endtask

    task automatic host_wr(input int a, input logic [31:0] d, input logic [3:0] be);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 7'(a); AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        step();
        clear_inputs();
    endtask

    task automatic host_rd(input int a);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 7'(a);
        step();
        clear_inputs();
    endtask

    task automatic eng_wr(input int a, input logic [31:0] d);
        ENG_WE = 1'b1; ENG_ADDR = 7'(a); ENG_WDATA = d;
        step();
        clear_inputs();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (BUSY !== 1'b0 && n < 300) begin step(); n++; end
        chk(nm, {31'd0, (n < 300)}, 32'd1);
    endtask

    function automatic logic [6:0] pick_addr();
        case ($urandom_range(0, 9))
            0: return 7'd0;
            1, 2, 3: return 7'd1;
            4: return 7'd2;
            5: return 7'd3;
            6: return 7'd22;
            7: return 7'd92;
            8: return 7'($urandom_range(93, 127));
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    function automatic logic [31:0] pick_n();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h2;
            3: return 32'h3;
            4: return 32'h0001_0000;
            default: return 32'($urandom_range(4, 6));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int n, p0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_start", {31'd0, FSM_START}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_rdata", AVL_READDATA, 32'd0);
        df_chk("rst", 1'b1);
        RESET = 1'b0;
        chk_on = 1'b1;

        host_wr(3, 32'h3F80_0000, 4'hF);
        host_rd(3);
        chk("rd_word3", AVL_READDATA, 32'h3F80_0000);
        chk("df_word3", datafile[3], 32'h3F80_0000);
        host_wr(4, 32'h1122_3344, 4'hF);
        host_wr(0, 32'h0000_0007, 4'hF);
        host_rd(100);
        chk("rd_oob", AVL_READDATA, 32'h0);

        hi_dly = 2; lo_dly = 0; p0 = pulses;
        host_wr(1, 32'd3, 4'h0);
        wait_idle("run3_timeout");
        step();
        chk("run3_pulses", pulses - p0, 32'd3);
        host_rd(2);
        chk("run3_status", AVL_READDATA, 32'h0003_0001);
        chk("run3_busy", {31'd0, BUSY}, 32'd0);

        hi_dly = 2; lo_dly = 2;
        host_wr(1, 32'd5, 4'hF);
        eng_wr(0, 32'hFFFF_FFFF);
        host_wr(4, 32'hDEAD_BEEF, 4'hF);
        n = 0;
        while (m_phase != 2 && n < 50) begin step(); n++; end
        chk("wait_rel", {31'd0, (n < 50)}, 32'd1);
        eng_wr(22, 32'h4000_0000);
        n = 0;
        while (!(m_phase == 1 && m_cnt == 16'd1) && n < 50) begin step(); n++; end
        chk("wait_step2", {31'd0, (n < 50)}, 32'd1);
        host_wr(1, 32'd0, 4'hF);
        wait_idle("abort_timeout");
        host_rd(2);
        chk("abort_status", AVL_READDATA, 32'h0002_0001);
        chk("eng_word22", datafile[22], 32'h4000_0000);
        chk("eng_word0", datafile[0], 32'h0000_0007);
        chk("lockout_word4", datafile[4], 32'h1122_3344);
        host_wr(4, 32'hDEAD_BEEF, 4'h3);
        chk("bytes_word4", datafile[4], 32'h1122_BEEF);

        eng_auto = 1'b0;
        FSM_DONE = 1'b1;
        host_wr(1, 32'd1, 4'hF);
        step();
        chk("early_done_start", {31'd0, FSM_START}, 32'd0);
        chk("early_done_busy", {31'd0, BUSY}, 32'd1);
        FSM_DONE = 1'b0;
        wait_idle("early_done_timeout");
        eng_auto = 1'b1; eng_age = 0; eng_low = 0;

        for (int it = 0; it < 2500; it++) begin
            int r;
            if ($urandom_range(0, 49) == 0) begin
                hi_dly = $urandom_range(0, 3); lo_dly = $urandom_range(0, 2);
            end
            r = $urandom_range(0, 9);
            AVL_ADDR = pick_addr();
            AVL_BYTE_EN = 4'($urandom_range(0, 15));
            AVL_WRITEDATA = (AVL_ADDR == 7'd1) ? pick_n() : $urandom();
            if (r < 2) begin AVL_CS = 1'b1; AVL_WRITE = 1'b1; end
            else if (r < 4) begin AVL_CS = 1'b1; AVL_READ = 1'b1; end
            else if (r == 4) begin AVL_READ = 1'b1; AVL_WRITE = 1'b1; end
            if ($urandom_range(0, 3) == 0) begin
                ENG_WE = 1'b1; ENG_ADDR = 7'($urandom_range(0, 127)); ENG_WDATA = $urandom();
            end
            step();
            clear_inputs();
        end
        wait_idle("random_drain");

        hi_dly = 3; lo_dly = 0;
        host_wr(1, 32'd5, 4'hF);
        chk("pre_rst_start", {31'd0, FSM_START}, 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("midrst_start", {31'd0, FSM_START}, 32'd0);
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        chk("midrst_rdata", AVL_READDATA, 32'd0);
        df_chk("midrst", 1'b1);
        model_reset();
        FSM_DONE = 1'b0; eng_age = 0; eng_low = 0;
        @(negedge CLK);
        RESET = 1'b0;
        host_rd(3);
        chk("post_rst_word3", AVL_READDATA, 32'd0);
        host_rd(1);
        chk("post_rst_word1", AVL_READDATA, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
